// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_pkg
// Brief    : LEGv8 control encodings, control bundle types and bubble constant.
// Revision : 1.0
// ============================================================================
package arm_ctrl_pkg;

    localparam logic [10:0] OP_LDUR     = 11'b11111000010;
    localparam logic [10:0] OP_STUR     = 11'b11111000000;
    localparam logic [10:0] OP_ADD      = 11'b10001011000;
    localparam logic [10:0] OP_SUB      = 11'b11001011000;
    localparam logic [10:0] OP_AND      = 11'b10001010000;
    localparam logic [10:0] OP_ORR      = 11'b10101010000;
    localparam logic [10:0] OP_CBZ      = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic [3:0] alucontrol;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Per-stage subsets: each pipeline register carries only what its stage and later ones read.
    typedef struct packed {
        logic       alusrc;
        logic [3:0] alucontrol;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       memtoreg;
        logic       regwrite;
    } ex_ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic branch;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/arm_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_decode
// Brief    : Combinational main + ALU decode of the 11-bit LEGv8 opcode.
// Revision : 1.0
// ============================================================================
module arm_ctrl_decode
    import arm_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output ctrl_t       o_ctrl
);

    ctrl_t      w_main;
    logic [1:0] w_aluop;
    logic       w_valid;
    logic [3:0] w_alucontrol;

    always_comb begin
        w_main  = CTRL_BUBBLE;
        w_aluop = ALUOP_MEM;
        w_valid = 1'b1;
        if (i_opcode == OP_LDUR) begin
            w_main.alusrc   = 1'b1;
            w_main.memtoreg = 1'b1;
            w_main.regwrite = 1'b1;
            w_main.memread  = 1'b1;
        end else if (i_opcode == OP_STUR) begin
            w_main.reg2loc  = 1'b1;
            w_main.alusrc   = 1'b1;
            w_main.memwrite = 1'b1;
        end else if ((i_opcode & OP_CBZ_MASK) == OP_CBZ) begin
            w_main.reg2loc  = 1'b1;
            w_main.branch   = 1'b1;
            w_aluop         = ALUOP_BRANCH;
        end else if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                     i_opcode == OP_AND || i_opcode == OP_ORR) begin
            w_main.regwrite = 1'b1;
            w_aluop         = ALUOP_RTYPE;
        end else begin
            w_valid = 1'b0;
        end
    end

    always_comb begin
        w_alucontrol = ALU_ADD;
        case (w_aluop)
            ALUOP_BRANCH: w_alucontrol = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (i_opcode)
                    OP_SUB:  w_alucontrol = ALU_SUB;
                    OP_AND:  w_alucontrol = ALU_AND;
                    OP_ORR:  w_alucontrol = ALU_ORR;
                    default: w_alucontrol = ALU_ADD;
                endcase
            end
            default: w_alucontrol = ALU_ADD;
        endcase
    end

    // Unknown opcodes must give a true all-zero bubble, including the ALU field.
    always_comb begin
        o_ctrl            = w_main;
        o_ctrl.alucontrol = w_valid ? w_alucontrol : 4'b0000;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipe_controller
// Brief    : Pipelined LEGv8 control with load-use stall and taken-branch flush.
// Revision : 1.0
// ============================================================================
module pipe_controller
    import arm_ctrl_pkg::*;
#(
    parameter bit HAZARD_EN = 1'b1,
    parameter int ZERO_REG  = 31,
    parameter int REGW      = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_id,
    input  logic            branch_taken_mem,
    output logic            id_reg2loc,
    output logic            stall,
    output logic            flush,
    output logic            ex_alusrc,
    output logic [3:0]      ex_alucontrol,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_branch,
    output logic [REGW-1:0] mem_rd,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [REGW-1:0] wb_rd
);

    localparam logic [REGW-1:0] C_ZERO_RD = REGW'(ZERO_REG);

    ctrl_t           w_id_ctrl;
    logic [REGW-1:0] w_rn, w_src2, w_id_rd;
    logic            w_uses_rn, w_uses_src2, w_load_use, w_hazard;
    logic            w_unused_bits;

    ex_ctrl_t        ex_q, ex_d;
    mem_ctrl_t       mem_q, mem_d;
    wb_ctrl_t        wb_q, wb_d;
    logic [REGW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;

    arm_ctrl_decode u_decode (
        .i_opcode (instr_id[31:21]),
        .o_ctrl   (w_id_ctrl)
    );

    assign w_unused_bits = ^instr_id[15:10];

    // reg2loc is exactly "second source is Rt", so it also picks the hazard compare field.
    assign w_rn        = REGW'(instr_id[9:5]);
    assign w_src2      = w_id_ctrl.reg2loc ? REGW'(instr_id[4:0]) : REGW'(instr_id[20:16]);
    assign w_id_rd     = w_id_ctrl.regwrite ? REGW'(instr_id[4:0]) : C_ZERO_RD;
    assign w_uses_rn   = w_id_ctrl.regwrite | w_id_ctrl.memwrite;
    assign w_uses_src2 = w_id_ctrl.reg2loc | (w_id_ctrl.regwrite & ~w_id_ctrl.memread);

    assign w_load_use = ex_q.memread & (ex_rd_q != C_ZERO_RD) &
                        ((w_uses_rn & (ex_rd_q == w_rn)) | (w_uses_src2 & (ex_rd_q == w_src2)));

    generate
        if (HAZARD_EN) begin : g_hazard
            assign w_hazard = w_load_use;
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign id_reg2loc = w_id_ctrl.reg2loc;
    assign flush      = branch_taken_mem & ~reset;
    assign stall      = w_hazard & ~flush & ~reset;

    always_comb begin
        wb_d.memtoreg  = mem_q.memtoreg;
        wb_d.regwrite  = mem_q.regwrite;
        wb_rd_d        = mem_rd_q;
        mem_d.memread  = ex_q.memread;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.branch   = ex_q.branch;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.regwrite = ex_q.regwrite;
        mem_rd_d       = ex_rd_q;
        ex_d.alusrc     = w_id_ctrl.alusrc;
        ex_d.alucontrol = w_id_ctrl.alucontrol;
        ex_d.memread    = w_id_ctrl.memread;
        ex_d.memwrite   = w_id_ctrl.memwrite;
        ex_d.branch     = w_id_ctrl.branch;
        ex_d.memtoreg   = w_id_ctrl.memtoreg;
        ex_d.regwrite   = w_id_ctrl.regwrite;
        ex_rd_d         = w_id_rd;
        if (flush) begin
            mem_d    = '0;
            mem_rd_d = C_ZERO_RD;
            ex_d     = '0;
            ex_rd_d  = C_ZERO_RD;
        end else if (stall) begin
            ex_d    = '0;
            ex_rd_d = C_ZERO_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rd_q  <= C_ZERO_RD;
            mem_rd_q <= C_ZERO_RD;
            wb_rd_q  <= C_ZERO_RD;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            ex_rd_q  <= ex_rd_d;
            mem_rd_q <= mem_rd_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

    assign ex_alusrc     = ex_q.alusrc;
    assign ex_alucontrol = ex_q.alucontrol;
    assign mem_memread   = mem_q.memread;
    assign mem_memwrite  = mem_q.memwrite;
    assign mem_branch    = mem_q.branch;
    assign mem_rd        = mem_rd_q;
    assign wb_regwrite   = wb_q.regwrite;
    assign wb_memtoreg   = wb_q.memtoreg;
    assign wb_rd         = wb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_controller
// Brief    : Scoreboard bench for pipe_controller (stage timing, stall, flush).
// Revision : 1.0
// ============================================================================
module tb_pipe_controller;

    typedef struct packed {
        logic       alusrc;
        logic [3:0] aluctl;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       memtoreg;
        logic       regwrite;
        logic       reg2loc;
        logic [4:0] rd;
    } ref_t;

    typedef struct packed {
        logic       ex_alusrc;
        logic [3:0] ex_alucontrol;
        logic       mem_memread;
        logic       mem_memwrite;
        logic       mem_branch;
        logic [4:0] mem_rd;
        logic       wb_regwrite;
        logic       wb_memtoreg;
        logic [4:0] wb_rd;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_id = '0;
    logic        branch_taken_mem = 1'b0;

    logic       id_reg2loc, stall, flush, ex_alusrc, mem_memread, mem_memwrite, mem_branch;
    logic       wb_regwrite, wb_memtoreg;
    logic [3:0] ex_alucontrol;
    logic [4:0] mem_rd, wb_rd;

    logic       nh_reg2loc, nh_stall, nh_flush, nh_alusrc, nh_memread, nh_memwrite, nh_branch;
    logic       nh_regwrite, nh_memtoreg;
    logic [3:0] nh_alucontrol;
    logic [4:0] nh_mem_rd, nh_wb_rd;

    int errors = 0;
    int checks = 0;

    ref_t  m_ex, m_mem, m_wb;
    snap_t exp_q[$];

    localparam logic [10:0] T_LDUR = 11'h7C2;
    localparam logic [10:0] T_STUR = 11'h7C0;
    localparam logic [10:0] T_ADD  = 11'h458;
    localparam logic [10:0] T_SUB  = 11'h658;
    localparam logic [10:0] T_AND  = 11'h450;
    localparam logic [10:0] T_ORR  = 11'h550;

    always #5 clk = ~clk;

    pipe_controller #(.HAZARD_EN(1'b1), .ZERO_REG(31), .REGW(5)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .branch_taken_mem(branch_taken_mem),
        .id_reg2loc(id_reg2loc), .stall(stall), .flush(flush),
        .ex_alusrc(ex_alusrc), .ex_alucontrol(ex_alucontrol),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
        .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
    );

    pipe_controller #(.HAZARD_EN(1'b0), .ZERO_REG(31), .REGW(5)) dut_nohaz (
        .clk(clk), .reset(reset), .instr_id(instr_id), .branch_taken_mem(branch_taken_mem),
        .id_reg2loc(nh_reg2loc), .stall(nh_stall), .flush(nh_flush),
        .ex_alusrc(nh_alusrc), .ex_alucontrol(nh_alucontrol),
        .mem_memread(nh_memread), .mem_memwrite(nh_memwrite), .mem_branch(nh_branch),
        .mem_rd(nh_mem_rd), .wb_regwrite(nh_regwrite), .wb_memtoreg(nh_memtoreg), .wb_rd(nh_wb_rd)
    );

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rn,
                                          input logic [4:0] rt);
        return {op, 9'd8, 2'b00, rn, rt};
    endfunction

    // imm19 = 4 puts the value 4 into the Rn bit positions, which CBZ must ignore.
    function automatic logic [31:0] enc_cbz(input logic [4:0] rt);
        return {8'hB4, 19'd4, rt};
    endfunction

    function automatic ref_t bubble();
        ref_t r;
        r    = '0;
        r.rd = 5'd31;
        return r;
    endfunction

    function automatic ref_t ref_dec(input logic [31:0] ins);
        ref_t r;
        r = bubble();
        if (ins[31:21] == T_LDUR) begin
            r.alusrc = 1'b1; r.memtoreg = 1'b1; r.regwrite = 1'b1; r.memread = 1'b1; r.aluctl = 4'b0010;
        end else if (ins[31:21] == T_STUR) begin
            r.reg2loc = 1'b1; r.alusrc = 1'b1; r.memwrite = 1'b1; r.aluctl = 4'b0010;
        end else if (ins[31:24] == 8'hB4) begin
            r.reg2loc = 1'b1; r.branch = 1'b1; r.aluctl = 4'b0111;
        end else if (ins[31:21] == T_ADD) begin
            r.regwrite = 1'b1; r.aluctl = 4'b0010;
        end else if (ins[31:21] == T_SUB) begin
            r.regwrite = 1'b1; r.aluctl = 4'b0110;
        end else if (ins[31:21] == T_AND) begin
            r.regwrite = 1'b1; r.aluctl = 4'b0000;
        end else if (ins[31:21] == T_ORR) begin
            r.regwrite = 1'b1; r.aluctl = 4'b0001;
        end
        if (r.regwrite) r.rd = ins[4:0];
        return r;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.ex_alusrc     = m_ex.alusrc;
        s.ex_alucontrol = m_ex.aluctl;
        s.mem_memread   = m_mem.memread;
        s.mem_memwrite  = m_mem.memwrite;
        s.mem_branch    = m_mem.branch;
        s.mem_rd        = m_mem.rd;
        s.wb_regwrite   = m_wb.regwrite;
        s.wb_memtoreg   = m_wb.memtoreg;
        s.wb_rd         = m_wb.rd;
        return s;
    endfunction

    // One clock: drive, compare the pending expected stage snapshot, advance the model.
    task automatic cycle(input logic [31:0] ins, input logic br, input logic rst,
                         input logic exp_stall, input string tag);
        ref_t  d;
        snap_t exp_s, got;
        reset            = rst;
        instr_id         = ins;
        branch_taken_mem = br;
        d = ref_dec(ins);
        @(negedge clk);
        checks++;
        if (stall !== exp_stall) begin
            errors++; $display("FAIL %s stall: got %b expected %b", tag, stall, exp_stall);
        end
        checks++;
        if (flush !== (br & ~rst)) begin
            errors++; $display("FAIL %s flush: got %b expected %b", tag, flush, br & ~rst);
        end
        checks++;
        if (id_reg2loc !== d.reg2loc) begin
            errors++; $display("FAIL %s id_reg2loc: got %b expected %b", tag, id_reg2loc, d.reg2loc);
        end
        checks++;
        if (nh_stall !== 1'b0) begin
            errors++; $display("FAIL %s nohaz_stall: got %b expected 0", tag, nh_stall);
        end
        if (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            got.ex_alusrc     = ex_alusrc;
            got.ex_alucontrol = ex_alucontrol;
            got.mem_memread   = mem_memread;
            got.mem_memwrite  = mem_memwrite;
            got.mem_branch    = mem_branch;
            got.mem_rd        = mem_rd;
            got.wb_regwrite   = wb_regwrite;
            got.wb_memtoreg   = wb_memtoreg;
            got.wb_rd         = wb_rd;
            checks++;
            if (got !== exp_s) begin
                errors++; $display("FAIL %s stages: got %h expected %h", tag, got, exp_s);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        end else if (br) begin
            m_wb = m_mem; m_mem = bubble(); m_ex = bubble();
        end else if (exp_stall) begin
            m_wb = m_mem; m_mem = m_ex; m_ex = bubble();
        end else begin
            m_wb = m_mem; m_mem = m_ex; m_ex = d;
        end
        exp_q.push_back(model_snap());
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) cycle(32'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic test_reset();
        cycle(32'd0, 1'b0, 1'b1, 1'b0, "reset0");
        cycle(32'd0, 1'b0, 1'b1, 1'b0, "reset1");
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "reset_rel0");
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "reset_rel1");
    endtask

    task automatic test_add();
        cycle(enc_r(T_ADD, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, "add");
        checks++;
        if (ex_alucontrol !== 4'b0010) begin
            errors++; $display("FAIL add_ex_alu: got %b expected 0010", ex_alucontrol);
        end
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "add_b1");
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "add_b2");
        checks++;
        if (wb_regwrite !== 1'b1 || wb_rd !== 5'd2) begin
            errors++; $display("FAIL add_wb: got regwrite=%b rd=%0d expected 1/2", wb_regwrite, wb_rd);
        end
        drain("add_drain");
    endtask

    task automatic test_load_use();
        logic [31:0] first  [10];
        logic [31:0] second [10];
        logic        hz     [10];
        first[0] = enc_d(T_LDUR, 5'd5, 5'd1);  second[0] = enc_r(T_ADD, 5'd3, 5'd1, 5'd2);   hz[0] = 1'b1;
        first[1] = enc_d(T_LDUR, 5'd5, 5'd4);  second[1] = enc_r(T_SUB, 5'd4, 5'd7, 5'd6);   hz[1] = 1'b1;
        first[2] = enc_d(T_LDUR, 5'd2, 5'd9);  second[2] = enc_d(T_STUR, 5'd3, 5'd9);        hz[2] = 1'b1;
        first[3] = enc_d(T_LDUR, 5'd5, 5'd1);  second[3] = enc_cbz(5'd1);                    hz[3] = 1'b1;
        first[4] = enc_d(T_LDUR, 5'd6, 5'd5);  second[4] = enc_d(T_LDUR, 5'd5, 5'd7);        hz[4] = 1'b1;
        first[5] = enc_d(T_LDUR, 5'd5, 5'd1);  second[5] = enc_r(T_ADD, 5'd4, 5'd3, 5'd2);   hz[5] = 1'b0;
        first[6] = enc_d(T_LDUR, 5'd5, 5'd8);  second[6] = enc_d(T_LDUR, 5'd3, 5'd8);        hz[6] = 1'b0;
        first[7] = enc_d(T_LDUR, 5'd5, 5'd31); second[7] = enc_r(T_ADD, 5'd31, 5'd31, 5'd2); hz[7] = 1'b0;
        first[8] = enc_d(T_STUR, 5'd5, 5'd1);  second[8] = enc_r(T_ADD, 5'd3, 5'd1, 5'd2);   hz[8] = 1'b0;
        first[9] = enc_d(T_LDUR, 5'd5, 5'd4);  second[9] = enc_cbz(5'd2);                    hz[9] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(first[i], 1'b0, 1'b0, 1'b0, $sformatf("lu%0d_first", i));
            cycle(second[i], 1'b0, 1'b0, hz[i], $sformatf("lu%0d_second", i));
            if (hz[i]) begin
                checks++;
                if (ex_alusrc !== 1'b0 || ex_alucontrol !== 4'b0000) begin
                    errors++; $display("FAIL lu%0d_bubble: got alusrc=%b alu=%b expected 0/0000",
                                       i, ex_alusrc, ex_alucontrol);
                end
                cycle(second[i], 1'b0, 1'b0, 1'b0, $sformatf("lu%0d_retry", i));
            end
            drain($sformatf("lu%0d_drain", i));
        end
    endtask

    task automatic test_flush();
        cycle(enc_cbz(5'd0), 1'b0, 1'b0, 1'b0, "fl_cbz");
        cycle(enc_d(T_LDUR, 5'd5, 5'd1), 1'b0, 1'b0, 1'b0, "fl_ldur");
        cycle(enc_r(T_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, "fl_taken");
        checks++;
        if (ex_alusrc !== 1'b0 || ex_alucontrol !== 4'b0000 || mem_memread !== 1'b0 ||
            mem_branch !== 1'b0 || mem_rd !== 5'd31) begin
            errors++; $display("FAIL fl_squash: got ex=%b/%b mem=%b/%b/%0d expected 0/0000 0/0/31",
                               ex_alusrc, ex_alucontrol, mem_memread, mem_branch, mem_rd);
        end
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "fl_after");
        drain("fl_drain");
    endtask

    task automatic test_back_to_back();
        cycle(enc_r(T_ADD, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, "b2b_add");
        cycle(enc_r(T_SUB, 5'd6, 5'd5, 5'd4), 1'b0, 1'b0, 1'b0, "b2b_sub");
        cycle(enc_r(T_AND, 5'd9, 5'd8, 5'd7), 1'b0, 1'b0, 1'b0, "b2b_and");
        cycle(enc_r(T_ORR, 5'd12, 5'd11, 5'd10), 1'b0, 1'b0, 1'b0, "b2b_orr");
        cycle(enc_d(T_STUR, 5'd14, 5'd13), 1'b0, 1'b0, 1'b0, "b2b_stur");
        cycle(enc_cbz(5'd15), 1'b0, 1'b0, 1'b0, "b2b_cbz");
        drain("b2b_drain");
    endtask

    task automatic test_invalid();
        cycle(32'hFFE0_0021, 1'b0, 1'b0, 1'b0, "inv");
        checks++;
        if (ex_alusrc !== 1'b0 || ex_alucontrol !== 4'b0000) begin
            errors++; $display("FAIL inv_ex: got alusrc=%b alu=%b expected 0/0000", ex_alusrc, ex_alucontrol);
        end
        drain("inv_drain");
    endtask

    task automatic test_reset_mid_stall();
        cycle(enc_d(T_LDUR, 5'd5, 5'd1), 1'b0, 1'b0, 1'b0, "rms_ldur");
        cycle(enc_r(T_ADD, 5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 1'b0, "rms_reset");
        checks++;
        if (mem_memread !== 1'b0 || mem_rd !== 5'd31 || wb_rd !== 5'd31 || ex_alusrc !== 1'b0) begin
            errors++; $display("FAIL rms_empty: got memread=%b mem_rd=%0d wb_rd=%0d alusrc=%b expected 0/31/31/0",
                               mem_memread, mem_rd, wb_rd, ex_alusrc);
        end
        cycle(32'd0, 1'b0, 1'b0, 1'b0, "rms_rel");
        drain("rms_drain");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        m_ex  = bubble();
        m_mem = bubble();
        m_wb  = bubble();
        test_reset();
        test_add();
        test_load_use();
        test_flush();
        test_back_to_back();
        test_invalid();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_controller.md
# pipe_controller

Pipelined successor to the single-cycle controller for the LEGv8 ARM processor. Decodes the instruction word held in IF/ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers, so each datapath stage reads controls aligned to its own instruction. It also detects load-use hazards, stalling one cycle and inserting a bubble, and squashes younger instructions when a branch resolves taken in MEM. It sits between the IF/ID register and the stage muxes of the pipelined datapath.

## Interface
- `HAZARD_EN`, default 1: 1 enables load-use stall detection; 0 gives a software-scheduled pipeline with `stall` tied to 0.
- `ZERO_REG`, default 31: register index that never causes a hazard (XZR).
- `REGW`, default 5: register index width.
- `clk` in 1: clock. Only clock.
- `reset` in 1: synchronous, active-high.
- `instr_id` in 32: IF/ID instruction word. Fields: opcode[31:21], Rm[20:16], Rn[9:5], Rt/Rd[4:0].
- `branch_taken_mem` in 1: `mem_branch & zero`, computed by the datapath.
- `id_reg2loc` out 1: combinational from `instr_id`; selects the second register-file read address.
- `stall` out 1: hold PC and IF/ID.
- `flush` out 1: clear IF/ID to zero on the next edge.
- `ex_alusrc` out 1, `ex_alucontrol` out 4: EX-stage controls.
- `mem_memread`, `mem_memwrite`, `mem_branch` out 1 each: MEM-stage controls. `mem_rd` out REGW.
- `wb_regwrite`, `wb_memtoreg` out 1 each: WB-stage controls. `wb_rd` out REGW.

## Operation
- Decode, with all other opcodes giving the all-zero bubble. Opcodes are the 11-bit field [31:21].
  - LDUR 11111000010: alusrc, memtoreg, regwrite, memread; aluop 00.
  - STUR 11111000000: reg2loc, alusrc, memwrite; aluop 00.
  - CBZ 10110100xxx: reg2loc, branch; aluop 01.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: regwrite; aluop 10.
- ALU decode:
  - aluop 00 → 0010.
  - aluop 01 → 0111 (pass B).
  - aluop 10 → ADD 0010, SUB 0110, AND 0000, ORR 0001.
- Register uses:
  - Rn is used by R-type, LDUR and STUR.
  - The second source is Rm for R-type and Rt for STUR and CBZ. It is used by R-type, STUR and CBZ.
- Destinations:
  - The destination is carried as Rd/Rt.
  - Stage rd is forced to `ZERO_REG` whenever that stage's regwrite is 0.
- Load-use:
  - `stall` = `HAZARD_EN` & ex_memread & ex_rd≠`ZERO_REG` & (rd matches a used Rn, or rd matches a used second source).
- Stage update each edge, in priority order:
  1. reset: all stage registers are zero, and every rd field is `ZERO_REG`.
  2. `branch_taken_mem`: ID/EX and EX/MEM take the bubble, MEM/WB takes EX/MEM, and `flush`=1.
  3. `stall`: ID/EX takes the bubble, and EX/MEM and MEM/WB advance.
  4. Otherwise all three registers advance.
- `flush` = `branch_taken_mem` & ~reset. When `flush` is asserted, `stall` is forced to 0.

## Timing
- `id_reg2loc` is combinational, with zero latency.
- An instruction in ID at edge N drives ex_* after N, mem_* after N+1 and wb_* after N+2.
- `stall` and `flush` are combinational in the same cycle. The datapath samples them at the next edge.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and `stall` falls.
- Reset values, in and one cycle after reset: every registered output is 0, `mem_rd` and `wb_rd` are `ZERO_REG`, and `stall`=`flush`=0.
- A reset asserted mid-stall or mid-flush wins and empties all stages.
- A stall and a taken branch in the same cycle: the flush wins and no bubble is double-counted.
- An IF/ID word of all zeros (post-reset or post-flush) decodes to a bubble.

## Structure
- Package `arm_ctrl_pkg`:
  - opcode constants and the CBZ match mask;
  - aluop and alucontrol constants;
  - a packed struct `ctrl_t` {reg2loc, alusrc, alucontrol[3:0], memread, memwrite, branch, memtoreg, regwrite};
  - the `CTRL_BUBBLE` constant.
- Sub-module `arm_ctrl_decode`: purely combinational `instr[31:21]` → `ctrl_t`, combining the main and ALU decode.
- The top holds the three stage registers, the rd pipeline and the hazard/flush logic.

## Test plan
- Reset for 2 cycles, then release with `instr_id`=0: all controls read 0, rd outputs read 31, and `stall`/`flush` read 0.
- ADD X2,X1,X3 for one cycle, then bubbles: `ex_alucontrol`=0010 after 1 edge, `wb_regwrite`=1 and `wb_rd`=2 after 3 edges.
- LDUR X1 then ADD X2,X1,X3: `stall`=1 for exactly one cycle, and the following cycle has `ex_*`=0. The ADD reaches EX one cycle late with `ex_alucontrol`=0010.
- LDUR XZR then ADD using X31: `stall` never asserts. Repeated with `HAZARD_EN`=0 and LDUR X1 → ADD X1: `stall` stays 0.
- CBZ with `branch_taken_mem`=1 while a load-use pair sits in ID/EX: `flush`=1 and `stall`=0. Next cycle `ex_*`=0 and mem_* are 0.
- Invalid opcode 0x7FF: full bubble at every stage. Reset asserted mid-stall empties the pipeline in one edge.
